// File: rtl/prog_rom_dp_pkg.sv
// Shared types for the dual-port program memory: rv32i load funct3 codes and sequencer states.
package prog_rom_dp_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_funct3_e;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } prog_rom_state_e;

endpackage

// File: rtl/prog_rom_dp_load_align.sv
// Load data alignment: picks the byte/half lane of a word and sign- or zero-extends it.
module prog_rom_dp_load_align
    import prog_rom_dp_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[7:0];
        case (lane)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        // Halves use lane[1] only, so a misaligned half reads the aligned half.
        sel_half = lane[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = word;
        case (funct3)
            F3_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  result = {24'd0, sel_byte};
            F3_LH:   result = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  result = {16'd0, sel_half};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/prog_rom_dp.sv
// Dual-read program memory with host load port and HALT/LOAD/RUN sequencer.
// Define PROG_ROM_ERR_EN to add if_err/d_err range and alignment checking.
//
// Handshake: a request is accepted on a rising edge where req & ready; its rvalid/rdata
// appear right after that edge and last one cycle unless another request is accepted.
module prog_rom_dp
    import prog_rom_dp_pkg::*;
#(
    parameter int          ADDR_LENGTH = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_req,
    input  logic [31:0]            if_addr,
    output logic                   if_ready,
    output logic                   if_rvalid,
    output logic [31:0]            if_rdata,
    input  logic                   d_req,
    input  logic [31:0]            d_addr,
    input  logic [2:0]             d_funct3,
    output logic                   d_ready,
    output logic                   d_rvalid,
    output logic [31:0]            d_rdata,
    input  logic                   ld_active,
    input  logic                   ld_we,
    input  logic [ADDR_LENGTH-1:0] ld_addr,
    input  logic [31:0]            ld_data,
    output logic [ADDR_LENGTH:0]   ld_count,
    output logic                   running,
`ifdef PROG_ROM_ERR_EN
    output logic                   if_err,
    output logic                   d_err,
`endif
    output prog_rom_state_e        state_dbg
);

    localparam int MEM_SIZE = 1 << ADDR_LENGTH;
    localparam logic [ADDR_LENGTH:0] COUNT_MAX = (ADDR_LENGTH+1)'(MEM_SIZE);
    localparam prog_rom_state_e RESET_STATE = (INIT_FILE != "") ? ST_RUN : ST_HALT;

    logic [31:0] mem [MEM_SIZE];

    prog_rom_state_e state;
    logic            ld_active_q;
    logic            if_acc;
    logic            d_acc;
    logic [31:0]     if_off;
    logic [31:0]     d_off;
    logic [ADDR_LENGTH-1:0] if_idx;
    logic [ADDR_LENGTH-1:0] d_idx;
    logic [31:0]     d_word;
    logic [1:0]      d_lane;
    logic [2:0]      d_f3;
    logic [31:0]     align_out;
    logic            unused_bits;

    assign state_dbg = state;
    assign running   = (state == ST_RUN);
    assign if_ready  = (state == ST_RUN) & ~ld_active;
    assign d_ready   = (state == ST_RUN) & ~ld_active;
    assign if_acc    = if_req & if_ready;
    assign d_acc     = d_req & d_ready;

    assign if_off = if_addr - BASE_ADDR;
    assign d_off  = d_addr - BASE_ADDR;
    assign if_idx = if_off[ADDR_LENGTH+1:2];
    assign d_idx  = d_off[ADDR_LENGTH+1:2];
    assign unused_bits = ^{if_off[31:ADDR_LENGTH+2], if_off[1:0],
                           d_off[31:ADDR_LENGTH+2], d_off[1:0]};

    logic if_err_c;
    logic d_err_c;
`ifdef PROG_ROM_ERR_EN
    always_comb begin
        if_err_c = (|if_off[31:ADDR_LENGTH+2]) | (|if_off[1:0]);
        d_err_c  = |d_off[31:ADDR_LENGTH+2];
        case (d_funct3)
            F3_LB, F3_LBU: d_err_c = d_err_c;
            F3_LH, F3_LHU: d_err_c = d_err_c | d_addr[0];
            F3_LW:         d_err_c = d_err_c | (|d_addr[1:0]);
            default:       d_err_c = 1'b1;
        endcase
    end
`else
    assign if_err_c = 1'b0;
    assign d_err_c  = 1'b0;
`endif

    // Sequencer: a load window always wins over RUN; its falling edge releases the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            case (state)
                ST_HALT: if (ld_active)  state <= ST_LOAD;
                ST_LOAD: if (!ld_active) state <= ST_RUN;
                ST_RUN:  if (ld_active)  state <= ST_LOAD;
                default: state <= ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_active_q <= 1'b0;
            ld_count    <= '0;
        end else begin
            ld_active_q <= ld_active;
            if (ld_active && !ld_active_q) begin
                ld_count <= ld_we ? (ADDR_LENGTH+1)'(1) : '0;
            end else if (ld_active && ld_we && ld_count != COUNT_MAX) begin
                ld_count <= ld_count + 1'b1;
            end
        end
    end

    // Array contents survive reset so a partial image stays in place.
    always_ff @(posedge clk) begin
        if (ld_active && ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    logic if_err_q;
    logic d_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err_q  <= 1'b0;
            d_rvalid  <= 1'b0;
            d_word    <= '0;
            d_lane    <= '0;
            d_f3      <= 3'(F3_LW);
            d_err_q   <= 1'b0;
        end else begin
            if_rvalid <= if_acc;
            if_err_q  <= if_acc & if_err_c;
            if (if_acc) begin
                if_rdata <= if_err_c ? 32'd0 : mem[if_idx];
            end
            d_rvalid <= d_acc;
            d_err_q  <= d_acc & d_err_c;
            if (d_acc) begin
                d_word <= mem[d_idx];
                d_lane <= d_addr[1:0];
                d_f3   <= d_funct3;
            end
        end
    end

    prog_rom_dp_load_align u_load_align (
        .word   (d_word),
        .lane   (d_lane),
        .funct3 (d_f3),
        .result (align_out)
    );

    assign d_rdata = d_err_q ? 32'd0 : align_out;

`ifdef PROG_ROM_ERR_EN
    assign if_err = if_err_q;
    assign d_err  = d_err_q;
`endif

endmodule

// File: tb/tb_prog_rom_dp.sv
// Self-checking bench for prog_rom_dp: scoreboard queues per read port, one task per scenario.
module tb_prog_rom_dp;
    import prog_rom_dp_pkg::*;

    localparam int AL = 12;
    localparam int MEM_SIZE = 1 << AL;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_ready;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic [31:0]   d_addr;
    logic [2:0]    d_funct3;
    logic          d_ready;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          ld_active;
    logic          ld_we;
    logic [AL-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic [AL:0]   ld_count;
    logic          running;
    prog_rom_state_e state_dbg;
`ifdef PROG_ROM_ERR_EN
    logic          if_err;
    logic          d_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] if_exp_q[$];
    logic [31:0] d_exp_q[$];

    prog_rom_dp #(.ADDR_LENGTH(AL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_funct3  (d_funct3),
        .d_ready   (d_ready),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ld_active (ld_active),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_count  (ld_count),
        .running   (running),
`ifdef PROG_ROM_ERR_EN
        .if_err    (if_err),
        .d_err     (d_err),
`endif
        .state_dbg (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic open_window;
        ld_active = 1'b1;
        tick();
    endtask

    task automatic host_write(input logic [AL-1:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic close_window;
        ld_we = 1'b0; ld_active = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_funct3 = 3'b010;
        ld_active = 0; ld_we = 0; ld_addr = 0; ld_data = 0;
        repeat (2) tick();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b required 0", running); end
        checks++; if (if_ready !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b/%b required 0/0", if_ready, d_ready); end
        checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b/%b required 0/0", if_rvalid, d_rvalid); end
        checks++; if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h/%h required 0/0", if_rdata, d_rdata); end
        checks++; if (ld_count !== '0) begin errors++; $display("FAIL reset_ld_count: got %0d required 0", ld_count); end
        rst_n = 1'b1;
        if_req = 1'b1;
        tick();
        if_req = 1'b0;
        checks++; if (state_dbg !== ST_HALT || if_rvalid !== 1'b0) begin errors++; $display("FAIL halt_hold: got state %0d rvalid %b required HALT 0", state_dbg, if_rvalid); end
    endtask

    task automatic test_host_load;
        open_window();
        checks++; if (running !== 1'b0 || state_dbg !== ST_LOAD) begin errors++; $display("FAIL load_enter: got running %b state %0d required 0 LOAD", running, state_dbg); end
        for (int i = 0; i < 4; i++) host_write(AL'(i), 32'h1111_1111 * (i + 1));
        close_window();
        checks++; if (ld_count !== 13'd4) begin errors++; $display("FAIL load_count: got %0d required 4", ld_count); end
        checks++; if (running !== 1'b1 || if_ready !== 1'b1 || d_ready !== 1'b1) begin errors++; $display("FAIL load_run: got running %b ready %b/%b required 1 1/1", running, if_ready, d_ready); end
        // Writes outside the window must be ignored.
        host_write(AL'(3), 32'hDEAD_BEEF);
        checks++; if (ld_count !== 13'd4) begin errors++; $display("FAIL stray_count: got %0d required 4", ld_count); end
    endtask

    task automatic test_fetch_back_to_back;
        logic [31:0] a [4] = '{32'd0, 32'd4, 32'd8, 32'd12};
        logic [31:0] e [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        logic [31:0] exp;
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_addr = a[i]; if_exp_q.push_back(e[i]);
            tick();
            checks++;
            if (if_rvalid !== 1'b1 || if_exp_q.size() == 0) begin
                errors++; $display("FAIL fetch_b2b_valid[%0d]: got %b required 1", i, if_rvalid);
            end else begin
                exp = if_exp_q.pop_front();
                checks++; if (if_rdata !== exp) begin errors++; $display("FAIL fetch_b2b_data[%0d]: got %h required %h", i, if_rdata, exp); end
            end
        end
        if_req = 1'b0;
        tick();
        checks++; if (if_rvalid !== 1'b0 || if_exp_q.size() != 0) begin errors++; $display("FAIL fetch_idle: got rvalid %b pending %0d required 0 0", if_rvalid, if_exp_q.size()); end
    endtask

    task automatic test_load_align;
        logic [31:0] a [9] = '{32'd4, 32'd6, 32'd7, 32'd6, 32'd4, 32'd4, 32'd5, 32'd7, 32'd4};
        logic [2:0]  f [9] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b100, 3'b000, 3'b001};
        logic [31:0] e [9] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                               32'h80FF_7F01, 32'h0000_007F, 32'hFFFF_FF80, 32'h0000_7F01};
        logic [31:0] exp;
        open_window();
        host_write(AL'(1), 32'h80FF_7F01);
        close_window();
        checks++; if (ld_count !== 13'd1) begin errors++; $display("FAIL reload_count: got %0d required 1", ld_count); end
        d_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            d_addr = a[i]; d_funct3 = f[i]; d_exp_q.push_back(e[i]);
            tick();
            checks++;
            if (d_rvalid !== 1'b1 || d_exp_q.size() == 0) begin
                errors++; $display("FAIL align_valid[%0d]: got %b required 1", i, d_rvalid);
            end else begin
                exp = d_exp_q.pop_front();
                checks++; if (d_rdata !== exp) begin errors++; $display("FAIL align_data[%0d]: got %h required %h", i, d_rdata, exp); end
            end
        end
        d_req = 1'b0;
        tick();
        checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL align_idle: got %b required 0", d_rvalid); end
    endtask

    task automatic test_same_addr;
        logic [31:0] exp;
        if_req = 1'b1; if_addr = 32'd8; d_req = 1'b1; d_addr = 32'd8; d_funct3 = 3'b010;
        if_exp_q.push_back(32'h3333_3333); d_exp_q.push_back(32'h3333_3333);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        exp = if_exp_q.pop_front();
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== exp) begin errors++; $display("FAIL same_addr_if: got %b %h required 1 %h", if_rvalid, if_rdata, exp); end
        exp = d_exp_q.pop_front();
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== exp) begin errors++; $display("FAIL same_addr_d: got %b %h required 1 %h", d_rvalid, d_rdata, exp); end
        tick();
    endtask

    task automatic test_async_reset_run;
        if_req = 1'b1; if_addr = 32'd4;
        tick();
        if_req = 1'b0;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h80FF_7F01) begin errors++; $display("FAIL pre_reset_fetch: got %b %h required 1 80ff7f01", if_rvalid, if_rdata); end
        rst_n = 1'b0;
        #1;
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'd0 || running !== 1'b0) begin errors++; $display("FAIL async_reset_run: got rvalid %b rdata %h running %b required 0 0 0", if_rvalid, if_rdata, running); end
        tick();
        rst_n = 1'b1;
        open_window();
        close_window();
        checks++; if (running !== 1'b1 || ld_count !== '0) begin errors++; $display("FAIL empty_window: got running %b count %0d required 1 0", running, ld_count); end
    endtask

    task automatic test_load_interrupt;
        logic [31:0] exp;
        if_req = 1'b1; if_addr = 32'd0; d_req = 1'b1; d_addr = 32'd4; d_funct3 = 3'b010;
        if_exp_q.push_back(32'h1111_1111); d_exp_q.push_back(32'h80FF_7F01);
        tick();
        ld_active = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL load_block_ready: got %b/%b required 0/0", if_ready, d_ready); end
        exp = if_exp_q.pop_front();
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== exp) begin errors++; $display("FAIL inflight_if: got %b %h required 1 %h", if_rvalid, if_rdata, exp); end
        exp = d_exp_q.pop_front();
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== exp) begin errors++; $display("FAIL inflight_d: got %b %h required 1 %h", d_rvalid, d_rdata, exp); end
        tick();
        checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL load_no_accept: got %b/%b running %b required 0/0 0", if_rvalid, d_rvalid, running); end
        host_write(AL'(5), 32'hA5A5_0005);
        host_write(AL'(6), 32'hA5A5_0006);
        checks++; if (ld_count !== 13'd2 || if_ready !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL mid_load: got count %0d ready %b rvalid %b required 2 0 0", ld_count, if_ready, if_rvalid); end
        if_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (state_dbg !== ST_HALT || ld_count !== '0) begin errors++; $display("FAIL reset_mid_load: got state %0d count %0d required HALT 0", state_dbg, ld_count); end
        tick();
        rst_n = 1'b1;
        host_write(AL'(7), 32'hA5A5_0007);
        close_window();
        checks++; if (running !== 1'b1 || ld_count !== 13'd1) begin errors++; $display("FAIL restart_window: got running %b count %0d required 1 1", running, ld_count); end
        if_req = 1'b1;
        if_addr = 32'd20; if_exp_q.push_back(32'hA5A5_0005);
        tick();
        exp = if_exp_q.pop_front();
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== exp) begin errors++; $display("FAIL partial_kept: got %b %h required 1 %h", if_rvalid, if_rdata, exp); end
        if_addr = 32'd28; if_exp_q.push_back(32'hA5A5_0007);
        tick();
        if_req = 1'b0;
        exp = if_exp_q.pop_front();
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== exp) begin errors++; $display("FAIL restart_data: got %b %h required 1 %h", if_rvalid, if_rdata, exp); end
        tick();
    endtask

    task automatic test_addr_edges;
        logic [31:0] exp;
`ifdef PROG_ROM_ERR_EN
        d_req = 1'b1; d_addr = 32'd2; d_funct3 = 3'b010; d_exp_q.push_back(32'd0);
        if_req = 1'b1; if_addr = 32'(4 * MEM_SIZE); if_exp_q.push_back(32'd0);
        tick();
        exp = d_exp_q.pop_front();
        checks++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== exp) begin errors++; $display("FAIL err_lw_misaligned: got %b %b %h required 1 1 %h", d_rvalid, d_err, d_rdata, exp); end
        exp = if_exp_q.pop_front();
        checks++; if (if_rvalid !== 1'b1 || if_err !== 1'b1 || if_rdata !== exp) begin errors++; $display("FAIL err_fetch_range: got %b %b %h required 1 1 %h", if_rvalid, if_err, if_rdata, exp); end
        d_addr = 32'd4; d_funct3 = 3'b011; d_exp_q.push_back(32'd0);
        if_addr = 32'd0; if_exp_q.push_back(32'h1111_1111);
        tick();
        exp = d_exp_q.pop_front();
        checks++; if (d_err !== 1'b1 || d_rdata !== exp) begin errors++; $display("FAIL err_funct3: got %b %h required 1 %h", d_err, d_rdata, exp); end
        exp = if_exp_q.pop_front();
        checks++; if (if_err !== 1'b0 || if_rdata !== exp) begin errors++; $display("FAIL err_fetch_ok: got %b %h required 0 %h", if_err, if_rdata, exp); end
`else
        d_req = 1'b1; d_addr = 32'd2; d_funct3 = 3'b010; d_exp_q.push_back(32'h1111_1111);
        if_req = 1'b1; if_addr = 32'(4 * MEM_SIZE); if_exp_q.push_back(32'h1111_1111);
        tick();
        exp = d_exp_q.pop_front();
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== exp) begin errors++; $display("FAIL lw_truncate: got %b %h required 1 %h", d_rvalid, d_rdata, exp); end
        exp = if_exp_q.pop_front();
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== exp) begin errors++; $display("FAIL fetch_wrap: got %b %h required 1 %h", if_rvalid, if_rdata, exp); end
        d_addr = 32'd4; d_funct3 = 3'b011; d_exp_q.push_back(32'h80FF_7F01);
        if_addr = 32'(4 * MEM_SIZE + 4); if_exp_q.push_back(32'h80FF_7F01);
        tick();
        exp = d_exp_q.pop_front();
        checks++; if (d_rdata !== exp) begin errors++; $display("FAIL funct3_as_lw: got %h required %h", d_rdata, exp); end
        exp = if_exp_q.pop_front();
        checks++; if (if_rdata !== exp) begin errors++; $display("FAIL fetch_wrap_w1: got %h required %h", if_rdata, exp); end
        d_addr = 32'd5; d_funct3 = 3'b001; d_exp_q.push_back(32'h0000_7F01);
        tick();
        exp = d_exp_q.pop_front();
        checks++; if (d_rdata !== exp) begin errors++; $display("FAIL lh_truncate: got %h required %h", d_rdata, exp); end
`endif
        if_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_count_saturate;
        logic [31:0] exp;
        open_window();
        ld_we = 1'b1;
        for (int i = 0; i <= MEM_SIZE; i++) begin
            ld_addr = i[AL-1:0]; ld_data = 32'(i);
            tick();
        end
        ld_we = 1'b0;
        checks++; if (ld_count !== 13'(MEM_SIZE)) begin errors++; $display("FAIL count_saturate: got %0d required %0d", ld_count, MEM_SIZE); end
        close_window();
        checks++; if (ld_count !== 13'(MEM_SIZE) || running !== 1'b1) begin errors++; $display("FAIL count_hold: got %0d running %b required %0d 1", ld_count, running, MEM_SIZE); end
        if_req = 1'b1; if_addr = 32'd0; if_exp_q.push_back(32'(MEM_SIZE));
        tick();
        if_req = 1'b0;
        exp = if_exp_q.pop_front();
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== exp) begin errors++; $display("FAIL last_write_wins: got %b %h required 1 %h", if_rvalid, if_rdata, exp); end
        tick();
    endtask

    initial begin
        test_reset();
        test_host_load();
        test_fetch_back_to_back();
        test_load_align();
        test_same_addr();
        test_async_reset_run();
        test_load_interrupt();
        test_addr_edges();
        test_count_saturate();
        checks++;
        if (if_exp_q.size() != 0 || d_exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d/%0d pending required 0/0", if_exp_q.size(), d_exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
